// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, field positions and FSM state type for the fetch/IF-ID stage
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;

    localparam logic [OPC_HI-OPC_LO:0] OPC_BEQ = 6'b000100;
    localparam logic [OPC_HI-OPC_LO:0] OPC_BNE = 6'b000101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FULL
    } fetch_state_t;

    function automatic logic is_branch_opc(input logic [OPC_HI-OPC_LO:0] opc);
        return (opc == OPC_BEQ) || (opc == OPC_BNE);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational extraction of register fields and branch flag from an instruction
module instr_field_decode
    import fetch_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [W-1:0]       rs,
    output logic [W-1:0]       rt,
    output logic [W-1:0]       rd,
    output logic               is_branch
);

    always_comb begin
        rs        = W'(instr[RS_HI:RS_LO]);
        rt        = W'(instr[RT_HI:RT_LO]);
        rd        = W'(instr[RD_HI:RD_LO]);
        is_branch = is_branch_opc(instr[OPC_HI:OPC_LO]);
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - PC owner, req/ack instruction fetch, one-entry skid and registered IF/ID outputs
module fetch_decode_stage
    import fetch_pkg::*;
#(
    parameter int              W        = 5,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [W-1:0]       id_rs,
    output logic [W-1:0]       id_rt,
    output logic [W-1:0]       id_rd,
    output logic               id_is_branch
);

    fetch_state_t state, state_nxt;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    hold_addr;
    logic               discard, discard_nxt;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic               load_mem, load_skid, load_from_skid, pc_inc;
    logic               slot_free;

    logic [W-1:0]       mem_rs, mem_rt, mem_rd;
    logic               mem_is_branch;
    logic [W-1:0]       skid_rs, skid_rt, skid_rd;
    logic               skid_is_branch;

    instr_field_decode #(.W(W)) u_dec_mem (
        .instr     (imem_rdata),
        .rs        (mem_rs),
        .rt        (mem_rt),
        .rd        (mem_rd),
        .is_branch (mem_is_branch)
    );

    instr_field_decode #(.W(W)) u_dec_skid (
        .instr     (skid_instr),
        .rs        (skid_rs),
        .rt        (skid_rt),
        .rd        (skid_rd),
        .is_branch (skid_is_branch)
    );

    // After a redirect the old request is still in flight; keep its address on the bus until it acks.
    assign imem_addr = discard ? hold_addr : pc;
    assign slot_free = !id_valid || id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        discard_nxt    = discard;
        imem_req       = 1'b0;
        load_mem       = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        pc_inc         = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack && !redirect_valid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                    end else if (slot_free) begin
                        load_mem = 1'b1;
                        pc_inc   = 1'b1;
                    end else begin
                        load_skid = 1'b1;
                        pc_inc    = 1'b1;
                        state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (id_ready && !redirect_valid) begin
                    load_from_skid = 1'b1;
                    state_nxt      = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Redirect overrides everything; only an unanswered request leaves an ack to be swallowed.
        if (redirect_valid) begin
            discard_nxt = (state == ST_REQ) && !imem_ack;
            if (state != ST_IDLE) begin
                state_nxt = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            hold_addr    <= '0;
            discard      <= 1'b0;
            skid_pc      <= '0;
            skid_instr   <= '0;
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_instr     <= '0;
            id_rs        <= '0;
            id_rt        <= '0;
            id_rd        <= '0;
            id_is_branch <= 1'b0;
        end else begin
            discard <= discard_nxt;
            if (redirect_valid) begin
                pc         <= redirect_pc & ~PC_W'(3);
                id_valid   <= 1'b0;
                skid_pc    <= '0;
                skid_instr <= '0;
                if (!discard) begin
                    hold_addr <= pc;
                end
            end else begin
                if (pc_inc) begin
                    pc <= pc + PC_W'(PC_INC);
                end
                if (load_skid) begin
                    skid_pc    <= pc;
                    skid_instr <= imem_rdata;
                end
                if (load_mem) begin
                    id_valid     <= 1'b1;
                    id_pc        <= pc;
                    id_instr     <= imem_rdata;
                    id_rs        <= mem_rs;
                    id_rt        <= mem_rt;
                    id_rd        <= mem_rd;
                    id_is_branch <= mem_is_branch;
                end else if (load_from_skid) begin
                    id_valid     <= 1'b1;
                    id_pc        <= skid_pc;
                    id_instr     <= skid_instr;
                    id_rs        <= skid_rs;
                    id_rt        <= skid_rt;
                    id_rd        <= skid_rd;
                    id_is_branch <= skid_is_branch;
                end else if (id_valid && id_ready) begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - directed self-checking bench for fetch_decode_stage
module tb_fetch_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_is_branch;

    int total = 0;
    int bad   = 0;

    fetch_decode_stage #(.W(5), .PC_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_is_branch   (id_is_branch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        tick(); tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        rst_n = 1'b1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        imem_ack = 1'b1; id_ready = 1'b1; imem_rdata = 32'h1085_0003;
        tick();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL s0_valid got=%b exp=1", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL s0_pc got=%h exp=0", id_pc); end
        total++; if (id_instr !== 32'h1085_0003) begin bad++; $display("FAIL s0_instr got=%h exp=10850003", id_instr); end
        total++; if (id_rs !== 5'd4) begin bad++; $display("FAIL s0_rs got=%0d exp=4", id_rs); end
        total++; if (id_rt !== 5'd5) begin bad++; $display("FAIL s0_rt got=%0d exp=5", id_rt); end
        total++; if (id_is_branch !== 1'b1) begin bad++; $display("FAIL s0_branch got=%b exp=1", id_is_branch); end
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL s0_addr got=%h exp=4", imem_addr); end
        imem_rdata = 32'h0085_1020;
        tick();
        total++; if (id_is_branch !== 1'b0) begin bad++; $display("FAIL s1_branch got=%b exp=0", id_is_branch); end
        total++; if (id_rd !== 5'd2) begin bad++; $display("FAIL s1_rd got=%0d exp=2", id_rd); end
        total++; if (id_pc !== 32'h4) begin bad++; $display("FAIL s1_pc got=%h exp=4", id_pc); end
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL s1_addr got=%h exp=8", imem_addr); end
        imem_rdata = 32'h2222_3333;
        tick();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL s2_valid got=%b exp=1", id_valid); end
        total++; if (id_pc !== 32'h8) begin bad++; $display("FAIL s2_pc got=%h exp=8", id_pc); end
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL s2_addr got=%h exp=c", imem_addr); end
    endtask

    task automatic test_back_pressure();
        imem_ack = 1'b0; id_ready = 1'b1;
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", id_valid); end
        id_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
        tick();
        total++; if (id_instr !== 32'h0123_4567) begin bad++; $display("FAIL bp_a_instr got=%h exp=01234567", id_instr); end
        total++; if (id_pc !== 32'hC) begin bad++; $display("FAIL bp_a_pc got=%h exp=c", id_pc); end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL bp_a_addr got=%h exp=10", imem_addr); end
        imem_rdata = 32'h1443_0001;
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_req got=%b exp=0", imem_req); end
        total++; if (id_instr !== 32'h0123_4567) begin bad++; $display("FAIL bp_hold_instr got=%h exp=01234567", id_instr); end
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL bp_full_addr got=%h exp=14", imem_addr); end
        imem_ack = 1'b0;
        tick();
        total++; if (id_instr !== 32'h0123_4567) begin bad++; $display("FAIL bp_hold2_instr got=%h exp=01234567", id_instr); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_hold2_req got=%b exp=0", imem_req); end
        id_ready = 1'b1;
        tick();
        total++; if (id_instr !== 32'h1443_0001) begin bad++; $display("FAIL bp_skid_instr got=%h exp=14430001", id_instr); end
        total++; if (id_pc !== 32'h10) begin bad++; $display("FAIL bp_skid_pc got=%h exp=10", id_pc); end
        total++; if (id_is_branch !== 1'b1) begin bad++; $display("FAIL bp_skid_branch got=%b exp=1", id_is_branch); end
        total++; if (id_rs !== 5'd2) begin bad++; $display("FAIL bp_skid_rs got=%0d exp=2", id_rs); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL bp_skid_valid got=%b exp=1", id_valid); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL bp_req_back got=%b exp=1", imem_req); end
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bp_consumed got=%b exp=0", id_valid); end
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL bp_end_addr got=%h exp=14", imem_addr); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; imem_ack = 1'b0;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL rd_hold_addr got=%h exp=14", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rd_req got=%b exp=1", imem_req); end
        tick(); tick();
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL rd_hold_addr2 got=%h exp=14", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rd_drop_valid got=%b exp=0", id_valid); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rd_new_addr got=%h exp=100", imem_addr); end
        imem_rdata = 32'h0085_1020;
        tick();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL rd_new_valid got=%b exp=1", id_valid); end
        total++; if (id_pc !== 32'h100) begin bad++; $display("FAIL rd_new_pc got=%h exp=100", id_pc); end
        total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL rd_next_addr got=%h exp=104", imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; imem_rdata = 32'h1443_0001;
        tick();
        redirect_valid = 1'b0;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rd_ack_valid got=%b exp=0", id_valid); end
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL rd_ack_addr got=%h exp=200", imem_addr); end
    endtask

    task automatic test_pc_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h0;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre_addr got=%h exp=fffffffc", imem_addr); end
        imem_rdata = 32'h1085_0003;
        tick();
        total++; if (id_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=fffffffc", id_pc); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", id_valid); end
    endtask

    task automatic test_async_reset();
        imem_ack = 1'b0; id_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ar_req got=%b exp=0", imem_req); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL ar_pc got=%h exp=0", id_pc); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL ar_instr got=%h exp=0", id_instr); end
        total++; if ({id_rs, id_rt, id_rd, id_is_branch} !== 16'h0) begin bad++; $display("FAIL ar_fields got=%h exp=0", {id_rs, id_rt, id_rd, id_is_branch}); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL ar_addr got=%h exp=0", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0085_1020; id_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL ar_stale_ack got=%b exp=0", id_valid); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL ar_req_again got=%b exp=1", imem_req); end
        tick();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL ar_reload_valid got=%b exp=1", id_valid); end
        total++; if (id_rd !== 5'd2) begin bad++; $display("FAIL ar_reload_rd got=%0d exp=2", id_rd); end
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL ar_reload_addr got=%h exp=4", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_pc_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
Instruction fetch plus IF/ID pipeline stage directly upstream of the branch register-select mux in the datapath. It owns the PC, fetches 32-bit instructions over a req/ack memory handshake, and buffers one instruction in a skid register. It presents registered decoded fields to the decode stage: rs/rt/rd addresses and is_branch, which drive the mux's R1/R3/isBranch inputs. Decode consumes them through a valid/ready handshake; execute can redirect the PC.

Parameters:
W, 5, register-address width (rs/rt/rd fields)
PC_W, 32, PC and instruction-memory address width
RESET_PC, 0, PC value loaded at reset (word-aligned)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request
imem_addr  output  PC_W  fetch address, word-aligned
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
redirect_valid  input  1  single-cycle PC redirect (branch taken)
redirect_pc  input  PC_W  new PC; bits [1:0] ignored, forced 0
id_valid  output  1  decoded instruction available
id_ready  input  1  decode stage accepts this cycle
id_pc  output  PC_W  PC of presented instruction
id_instr  output  32  presented instruction
id_rs  output  W  instr[25:21], feeds mux R1 side
id_rt  output  W  instr[20:16]
id_rd  output  W  instr[15:11], feeds mux R3 side
id_is_branch  output  1  opcode instr[31:26] is BEQ 6'b000100 or BNE 6'b000101

Behaviour:
- Reset, asynchronous on rst_n low: pc=RESET_PC; state IDLE; imem_req=0; id_valid=0; id_pc, id_instr, id_rs, id_rt, id_rd, id_is_branch all 0; skid empty; discard=0. Reset mid-request abandons the request; a stale ack after reset is ignored because state is IDLE.
- FSM states: IDLE, REQ, FULL.
- IDLE: imem_req=0. Go to REQ next cycle, so the first request is asserted in the 2nd cycle after reset deassertion.
- REQ: imem_req=1, imem_addr=pc. Both stay stable until imem_ack.
- Ack, output slot free (id_valid==0, or id_ready==1 this cycle): load the output register with instr, pc, and decoded fields; id_valid=1; pc+=4; stay in REQ. This gives one instruction per cycle when imem_ack is combinational-high.
- Ack, output slot held (id_valid==1 and id_ready==0): write instr/pc into the skid register; pc+=4; go to FULL.
- FULL: imem_req=0. When id_ready==1, move the skid register to the output (id_valid stays 1) and go to REQ.
- Fetch-to-output latency: the output register updates on the edge where ack is sampled.
- Handshake: id_* fields are stable while id_valid==1 and id_ready==0. A transfer occurs on cycles where id_valid and id_ready are both 1.
- PC arithmetic: pc+4 wraps modulo 2^PC_W, e.g. 32'hFFFF_FFFC -> 0.
- Redirect has highest priority over every other event in the same cycle:
  - pc<=redirect_pc & ~3; id_valid<=0; skid cleared.
  - Redirect while in REQ with no ack this cycle: discard<=1. The next ack is dropped (no load, no pc increment), discard clears, and the next request uses the redirect PC.
  - Redirect on the same cycle as an ack: that ack's data is dropped and discard stays 0.
  - Redirect while in FULL: go to REQ.
  - Redirect and id_ready on the same cycle: the presented instruction is still counted as consumed by decode.
- While discard==1, imem_addr stays at the outstanding request's address until its ack.

Decomposition:
- Package fetch_pkg holds: OPC_BEQ, OPC_BNE, field-position constants (OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO), INSTR_W=32, the FSM state enum, and PC_INC=4.
- Sub-module instr_field_decode is purely combinational (instr in -> rs, rt, rd, is_branch). It is used twice: once on imem_rdata, once on the skid register output.

Test Plan:
- Reset, RESET_PC=0, imem_ack tied high, id_ready=1 -> imem_addr 0,4,8,12 on consecutive cycles; id_valid stays 1 from the first ack.
- Fetch instr 32'h1085_0003 (BEQ, rs=4, rt=5) -> id_is_branch=1, id_rs=4, id_rt=5. Fetch 32'h0085_1020 -> id_is_branch=0, id_rd=2.
- Hold id_ready=0 across two acks -> first instr on output, second in skid, state FULL, imem_req=0. Raise id_ready for one cycle -> skid instr presented, imem_req returns high.
- Assert redirect_valid with redirect_pc=32'h0000_0103 while a request is outstanding; ack 3 cycles later -> that data is dropped, next imem_addr=32'h100, id_valid=0 until the new ack.
- Set pc=32'hFFFF_FFFC, ack -> next imem_addr=0.
- Pull rst_n low mid-request with id_valid=1 -> imem_req, id_valid and all id_* fields are 0 immediately, without a clock edge.
